// File: rtl/spi_master_core.sv
// SPI mode-0 master moving one full-duplex 32-bit word per transfer, MSB- or LSB-first.
// Optional build macro SPI_MASTER_SS_HOLD_EN keeps ss low across back-to-back words.
module spi_master_core #(
    parameter int WORD_W = 32,
    parameter int DIV_W  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mlb,
    input  logic              start,
    input  logic [WORD_W-1:0] tdat,
    input  logic [DIV_W-1:0]  cdiv,
    input  logic              din,
    output logic              ss,
    output logic              sck,
    output logic              dout,
    output logic              done,
    output logic [WORD_W-1:0] rdata
);
    localparam int BIT_W = $clog2(WORD_W);

    typedef enum logic [1:0] {IDLE, SEND, FINISH} state_t;
    state_t state, state_next;

    logic [WORD_W-1:0] tx_sh, rx_sh;
    logic              mlb_q;
    logic [DIV_W-1:0]  cdiv_q;
    logic [4:0]        div_cnt;
    logic [4:0]        half_m1;
    logic [BIT_W-1:0]  bit_cnt;
    logic              phase_end, rise, fall, last_fall, load;

    // Half-period H = 2 << cdiv clocks; the divider counts 0 .. H-1.
    assign half_m1 = (5'd2 << cdiv_q) - 5'd1;

    always_comb begin
        phase_end  = (state == SEND) && (div_cnt == half_m1);
        rise       = phase_end && !sck;
        fall       = phase_end && sck;
        last_fall  = fall && (bit_cnt == BIT_W'(WORD_W - 1));
        load       = (state == IDLE) && start;
`ifdef SPI_MASTER_SS_HOLD_EN
        load       = load || ((state == FINISH) && start);
`endif
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = SEND;
            SEND:    if (last_fall) state_next = FINISH;
            FINISH:  state_next = load ? SEND : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ss      <= 1'b1;
            sck     <= 1'b0;
            dout    <= 1'b0;
            done    <= 1'b0;
            rdata   <= '0;
            tx_sh   <= '0;
            rx_sh   <= '0;
            mlb_q   <= 1'b1;
            cdiv_q  <= '0;
            div_cnt <= '0;
            bit_cnt <= '0;
        end else begin
            done <= 1'b0;
            if (state == SEND) begin
                if (phase_end) begin
                    sck     <= ~sck;
                    div_cnt <= '0;
                end else begin
                    div_cnt <= div_cnt + 5'd1;
                end
                if (rise)
                    rx_sh <= mlb_q ? {rx_sh[WORD_W-2:0], din} : {din, rx_sh[WORD_W-1:1]};
                // The final fall leaves dout on the last bit instead of shifting further.
                if (fall && !last_fall) begin
                    tx_sh   <= mlb_q ? (tx_sh << 1) : (tx_sh >> 1);
                    dout    <= mlb_q ? tx_sh[WORD_W-2] : tx_sh[1];
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end
            if (state == FINISH) begin
                done  <= 1'b1;
                rdata <= rx_sh;
                sck   <= 1'b0;
                ss    <= 1'b1;
            end
            if (load) begin
                ss      <= 1'b0;
                sck     <= 1'b0;
                tx_sh   <= tdat;
                mlb_q   <= mlb;
                cdiv_q  <= cdiv;
                dout    <= mlb ? tdat[WORD_W-1] : tdat[0];
                div_cnt <= '0;
                bit_cnt <= '0;
            end
        end
    end
endmodule

// File: tb/tb_spi_master_core.sv
// Bench for spi_master_core: slave model on din, scoreboard queues checked by a monitor on done.
module tb_spi_master_core;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mlb = 1'b1;
    logic        start = 1'b0;
    logic [31:0] tdat = '0;
    logic [1:0]  cdiv = '0;
    logic        din;
    logic        ss, sck, dout, done;
    logic [31:0] rdata;

    spi_master_core dut (
        .clk(clk), .reset(reset), .mlb(mlb), .start(start), .tdat(tdat), .cdiv(cdiv),
        .din(din), .ss(ss), .sck(sck), .dout(dout), .done(done), .rdata(rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int tests = 0;
    int fails = 0;
    int done_cnt = 0;

    logic [31:0] exp_tx_q[$];
    logic [31:0] exp_rx_q[$];
    int          exp_cyc_q[$];

    // Slave side: shifts slave_word out in the chosen order, one bit per sck rise.
    logic        loop_en = 1'b0;
    logic        slave_mlb = 1'b1;
    logic [31:0] slave_word = '0;
    logic        slave_din = 1'b0;
    assign din = loop_en ? dout : slave_din;

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    initial begin
        int  idx;
        int  bi;
        logic prev;
        idx = 0;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (reset || ss) idx = 0;
            else if (sck && !prev) idx = idx + 1;
            prev = sck;
            bi = idx % 32;
            slave_din = slave_mlb ? slave_word[31 - bi] : slave_word[bi];
        end
    end

    function automatic logic [31:0] rev32(input logic [31:0] w);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = w[31 - i];
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests = tests + 1;
        if (act !== expv) begin
            fails = fails + 1;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Expected wire-order bit sequence, received word and done cycle for one transfer.
    task automatic push_exp(input logic [31:0] t, input logic m, input logic [1:0] c,
                            input logic lp, input logic [31:0] sw);
        int h;
        h = 2 << c;
        exp_tx_q.push_back(m ? t : rev32(t));
        exp_rx_q.push_back(lp ? t : sw);
        exp_cyc_q.push_back(cyc + 2 + 64 * h);
    endtask

    // Monitor: collects dout at every sck rise, compares against the scoreboard on done.
    initial begin
        logic [31:0] acc;
        int          nbits;
        logic        prev;
        acc = '0;
        nbits = 0;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                acc = '0;
                nbits = 0;
            end else begin
                if (sck && !prev) begin
                    acc = {acc[30:0], dout};
                    nbits = nbits + 1;
                    check("ss_low_at_rise", {31'b0, ss}, 32'd0);
                end
                if (done) begin
                    done_cnt = done_cnt + 1;
                    if (exp_tx_q.size() == 0) begin
                        tests = tests + 1;
                        fails = fails + 1;
                        $display("FAIL unexpected_done: got done=1 expected no pulse (cycle %0d)", cyc);
                    end else begin
                        check("tx_bits", acc, exp_tx_q.pop_front());
                        check("rdata", rdata, exp_rx_q.pop_front());
                        check("done_cycle", cyc, exp_cyc_q.pop_front());
                        check("bit_count", nbits, 32);
                    end
                    nbits = 0;
                    acc = '0;
                end
            end
            prev = sck;
        end
    end

    task automatic wait_done(input int target);
        for (int i = 0; i < 1100; i++) begin
            if (done_cnt >= target) return;
            @(negedge clk);
        end
        tests = tests + 1;
        fails = fails + 1;
        $display("FAIL done_timeout: got %0d done pulses expected %0d", done_cnt, target);
    endtask

    task automatic run_xfer(input logic [31:0] t, input logic m, input logic [1:0] c,
                            input logic lp, input logic [31:0] sw);
        int target;
        @(negedge clk);
        target = done_cnt + 1;
        tdat = t;
        mlb = m;
        cdiv = c;
        loop_en = lp;
        slave_mlb = m;
        slave_word = sw;
        start = 1'b1;
        push_exp(t, m, c, lp, sw);
        @(negedge clk);
        start = 1'b0;
        tdat = $urandom;
        mlb = $urandom_range(0, 1);
        cdiv = 2'($urandom_range(0, 3));
        wait_done(target);
    endtask

    // start held high; a new tdat is presented on every done cycle.
    task automatic run_b2b(input int n, input logic [1:0] c);
        logic [31:0] t, sw;
        int          k;
        @(negedge clk);
        t = $urandom;
        sw = $urandom;
        mlb = 1'b1;
        cdiv = c;
        loop_en = 1'b0;
        slave_mlb = 1'b1;
        tdat = t;
        slave_word = sw;
        start = 1'b1;
        push_exp(t, 1'b1, c, 1'b0, sw);
        k = 0;
        for (int i = 0; i < n * 1100 && k < n; i++) begin
            @(negedge clk);
            if (done) begin
                k = k + 1;
                check("ss_gap_high", {31'b0, ss}, 32'd1);
                if (k < n) begin
                    t = $urandom;
                    sw = $urandom;
                    tdat = t;
                    slave_word = sw;
                    push_exp(t, 1'b1, c, 1'b0, sw);
                end else begin
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        if (k < n) begin
            tests = tests + 1;
            fails = fails + 1;
            $display("FAIL b2b_timeout: got %0d words expected %0d", k, n);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_ss"}, {31'b0, ss}, 32'd1);
        check({tag, "_sck"}, {31'b0, sck}, 32'd0);
        check({tag, "_dout"}, {31'b0, dout}, 32'd0);
        check({tag, "_done"}, {31'b0, done}, 32'd0);
        check({tag, "_rdata"}, rdata, 32'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        reset = 1'b0;

        run_xfer(32'hA5C3_0F01, 1'b1, 2'd0, 1'b1, 32'h0);
        run_xfer(32'h8000_0000, 1'b1, 2'd0, 1'b0, $urandom);
        run_xfer(32'h0000_0001, 1'b0, 2'd1, 1'b0, 32'h0000_0001);
        run_xfer($urandom, 1'b1, 2'd3, 1'b0, $urandom);
        run_xfer($urandom, 1'b0, 2'd2, 1'b1, 32'h0);

        for (int i = 0; i < 10; i++)
            run_xfer($urandom, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)),
                     1'($urandom_range(0, 1)), $urandom);

        run_b2b(3, 2'($urandom_range(0, 1)));

        // Abort a transfer with reset about 40 cycles in; no done may follow.
        @(negedge clk);
        tdat = $urandom;
        mlb = 1'b1;
        cdiv = 2'd0;
        loop_en = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (39) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_idle_outputs("abort");
        reset = 1'b0;
        repeat (200) @(negedge clk);

        run_xfer($urandom, 1'b1, 2'd0, 1'b0, $urandom);

        repeat (5) @(negedge clk);
        check("queue_empty", exp_tx_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
